// File: rtl/commutator_pkg.sv
// commutator_pkg
// Constants and types shared by the transmit-side commutator and the
// receive-side decommutator.
//
// Frame layout, one byte per clock:
//   header  {HDR_MARK, channel}
//   length  number of payload bytes
//   payload `length` bytes, passed through without interpretation
//
// The idle frame uses channel IDLE_CH and must carry a length of 0.
package commutator_pkg;

  // Receiver framing states
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2
  } state_t;

  // Header field widths
  localparam int MARK_W = 4;
  localparam int CH_W   = 4;
  localparam int LEN_W  = 8;

  // Width of the payload byte counter
  localparam int CNT_W  = 4;

  localparam logic [MARK_W-1:0] HDR_MARK = 4'hF;
  localparam logic [CH_W-1:0]   IDLE_CH  = 4'hF;
  localparam int                NUM_CH   = 3;
  localparam int                MAX_LEN  = 9;

endpackage

// File: rtl/channel_decoder.sv
// channel_decoder
// Turns a 4-bit channel code into a one-hot write-enable vector. This is the
// mirror of the transmitter's channel encoder.
//
// Ports:
//   code    in   CH_W    channel code
//   onehot  out  NUM_CH  one-hot vector, all zero when the code is not a data channel
//   valid   out  1       code addresses one of the data channels
module channel_decoder
  import commutator_pkg::*;
(
  input  logic [CH_W-1:0]   code,
  output logic [NUM_CH-1:0] onehot,
  output logic              valid
);

  // Codes 0..NUM_CH-1 select a channel. Every other code, including the
  // idle code, selects nothing.
  always_comb begin
    onehot = '0;
    valid  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (code == CH_W'(i)) begin
        onehot[i] = 1'b1;
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decommutator.sv
// decommutator
// Receive-side frame parser. It takes the framed byte stream from the link
// and writes each payload byte to its destination channel buffer.
//
// Optional feature: define DECOMM_ERR_CNT_EN to add a saturating 16-bit
// framing-error counter with a synchronous clear.
//
// Ports:
//   clk          in   1       clock
//   arst         in   1       asynchronous active-high reset
//   input_valid  in   1       input_data carries a stream byte this cycle
//   input_data   in   8       stream byte
//   write_req    out  NUM_CH  one-hot write strobe, one cycle wide
//   output_data  out  8       payload byte that goes with write_req
//   channel      out  4       channel code of the current frame
//   frame_done   out  1       pulse on the last payload write, or on the idle length byte
//   sync         out  1       receiver is locked to frame boundaries
//   error        out  1       one-cycle pulse on a framing violation
//   err_clr      in   1       (DECOMM_ERR_CNT_EN) synchronous clear of err_count
//   err_count    out  16      (DECOMM_ERR_CNT_EN) saturating error count
module decommutator
  import commutator_pkg::*;
(
  input  logic              clk,
  input  logic              arst,
  input  logic              input_valid,
  input  logic [7:0]        input_data,
  output logic [NUM_CH-1:0] write_req,
  output logic [7:0]        output_data,
  output logic [CH_W-1:0]   channel,
  output logic              frame_done,
  output logic              sync,
  output logic              error
`ifdef DECOMM_ERR_CNT_EN
  ,
  input  logic              err_clr,
  output logic [15:0]       err_count
`endif
);

  // The payload counter must be able to hold the largest length.
  if (MAX_LEN > (2 ** CNT_W) - 1) begin : g_max_len_check
    $error("decommutator: MAX_LEN does not fit the payload counter");
  end

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [NUM_CH-1:0]  ch_onehot;
  logic               ch_valid;
  logic               len_ok;

  channel_decoder u_channel_decoder (
    .code   (channel),
    .onehot (ch_onehot),
    .valid  (ch_valid)
  );

  // A data frame must carry between 1 and MAX_LEN payload bytes.
  assign len_ok = (input_data != 8'd0) && (input_data <= LEN_W'(MAX_LEN));

  // Framing FSM. The strobes default to zero, so a cycle with input_valid
  // low leaves the state alone and produces no pulse.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= HUNT;
      count       <= '0;
      write_req   <= '0;
      output_data <= 8'h00;
      channel     <= IDLE_CH;
      frame_done  <= 1'b0;
      sync        <= 1'b0;
      error       <= 1'b0;
    end else begin
      write_req  <= '0;
      frame_done <= 1'b0;
      error      <= 1'b0;
      if (input_valid) begin
        unique case (state)
          HUNT: begin
            if (input_data[7:4] == HDR_MARK) begin
              channel <= input_data[3:0];
              state   <= LEN;
            end else begin
              // Stray bytes are expected while hunting. Only losing an
              // existing lock counts as an error.
              error <= sync;
              sync  <= 1'b0;
            end
          end
          LEN: begin
            if (channel == IDLE_CH && input_data == 8'd0) begin
              frame_done <= 1'b1;
              sync       <= 1'b1;
              state      <= HUNT;
            end else if (ch_valid && len_ok) begin
              count <= input_data[CNT_W-1:0];
              sync  <= 1'b1;
              state <= DATA;
            end else begin
              error <= 1'b1;
              sync  <= 1'b0;
              state <= HUNT;
            end
          end
          DATA: begin
            // The payload is passed through as-is. A header-like byte here
            // is ordinary data and does not resynchronise the parser.
            output_data <= input_data;
            write_req   <= ch_onehot;
            count       <= count - 1'b1;
            if (count == CNT_W'(1)) begin
              frame_done <= 1'b1;
              state      <= HUNT;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

`ifdef DECOMM_ERR_CNT_EN
  // Counts registered error pulses and saturates at the top value. A clear
  // takes priority over an increment in the same cycle.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      err_count <= 16'h0000;
    end else if (err_clr) begin
      err_count <= 16'h0000;
    end else if (error && err_count != 16'hFFFF) begin
      err_count <= err_count + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_decommutator.sv
// tb_decommutator
// Directed self-checking bench for decommutator. Each task drives one scenario
// and compares the registered outputs one clock after each byte.
// Define DECOMM_ERR_CNT_EN to build the error-counter ports and their test.
module tb_decommutator;

  logic        clk;
  logic        arst;
  logic        input_valid;
  logic [7:0]  input_data;
  logic [2:0]  write_req;
  logic [7:0]  output_data;
  logic [3:0]  channel;
  logic        frame_done;
  logic        sync;
  logic        error;
`ifdef DECOMM_ERR_CNT_EN
  logic        err_clr;
  logic [15:0] err_count;
`endif

  int checks   = 0;
  int failures = 0;

  decommutator dut (
    .clk         (clk),
    .arst        (arst),
    .input_valid (input_valid),
    .input_data  (input_data),
    .write_req   (write_req),
    .output_data (output_data),
    .channel     (channel),
    .frame_done  (frame_done),
    .sync        (sync),
    .error       (error)
`ifdef DECOMM_ERR_CNT_EN
    ,
    .err_clr     (err_clr),
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  // Presents one stream byte on the falling edge. The task returns just after
  // the rising edge that registers that byte's result.
  task automatic apply_stimulus(input logic v, input logic [7:0] d);
    @(negedge clk);
    input_valid = v;
    input_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    input_valid = 1'b0;
    arst = 1'b1;
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    input_valid = 1'b1;
    input_data  = 8'hF1;
    arst        = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (write_req !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_write_req: got %b expected 000", write_req);
    end
    checks++;
    if (output_data !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_output_data: got %h expected 00", output_data);
    end
    checks++;
    if (channel !== 4'hF) begin
      failures++;
      $display("[TB] FAIL reset_channel: got %h expected f", channel);
    end
    checks++;
    if ({frame_done, sync, error} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_flags: got %b expected 000", {frame_done, sync, error});
    end
    @(negedge clk);
    arst = 1'b0;
    input_valid = 1'b0;
    apply_stimulus(1'b0, 8'h00);
    checks++;
    if ({write_req, frame_done, sync, error} !== 6'b000000) begin
      failures++;
      $display("[TB] FAIL reset_release: got %b expected 000000", {write_req, frame_done, sync, error});
    end
  endtask

  // F1,09,A0..A8 with nothing in front of it
  task automatic test_ch1_frame();
    apply_stimulus(1'b1, 8'hF1);
    checks++;
    if ({write_req, frame_done, error, channel} !== {3'b000, 1'b0, 1'b0, 4'h1}) begin
      failures++;
      $display("[TB] FAIL ch1_header: got wr=%b fd=%b err=%b ch=%h expected wr=000 fd=0 err=0 ch=1", write_req, frame_done, error, channel);
    end
    apply_stimulus(1'b1, 8'h09);
    checks++;
    if ({write_req, frame_done, error, sync} !== 6'b000001) begin
      failures++;
      $display("[TB] FAIL ch1_len: got %b expected 000001", {write_req, frame_done, error, sync});
    end
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1'b1, 8'(8'hA0 + i));
      checks++;
      if ({write_req, output_data, frame_done, error, sync} !== {3'b010, 8'(8'hA0 + i), (i == 8), 1'b0, 1'b1}) begin
        failures++;
        $display("[TB] FAIL ch1_byte%0d: got wr=%b d=%h fd=%b err=%b sync=%b expected wr=010 d=%h fd=%0d err=0 sync=1", i, write_req, output_data, frame_done, error, sync, 8'(8'hA0 + i), (i == 8));
      end
    end
  endtask

  // An idle frame followed directly by a channel 0 frame
  task automatic test_back_to_back();
    apply_stimulus(1'b1, 8'hFF);
    checks++;
    if ({write_req, frame_done, error} !== 5'b00000) begin
      failures++;
      $display("[TB] FAIL idle_header: got %b expected 00000", {write_req, frame_done, error});
    end
    apply_stimulus(1'b1, 8'h00);
    checks++;
    if ({write_req, frame_done, error, sync} !== 6'b000101) begin
      failures++;
      $display("[TB] FAIL idle_len: got %b expected 000101", {write_req, frame_done, error, sync});
    end
    apply_stimulus(1'b1, 8'hF0);
    apply_stimulus(1'b1, 8'h09);
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1'b1, 8'(i));
      checks++;
      if ({write_req, output_data, frame_done, error} !== {3'b001, 8'(i), (i == 8), 1'b0}) begin
        failures++;
        $display("[TB] FAIL b2b_byte%0d: got wr=%b d=%h fd=%b err=%b expected wr=001 d=%h fd=%0d err=0", i, write_req, output_data, frame_done, error, 8'(i), (i == 8));
      end
    end
  endtask

  // Rejected length bytes and unknown channels, then minimum and maximum lengths
  task automatic test_bad_frames();
    logic [7:0] bad [4][2];
    bad = '{'{8'hF2, 8'h0A}, '{8'hF0, 8'h00}, '{8'hFF, 8'h01}, '{8'hF5, 8'h00}};
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b1, bad[k][0]);
      apply_stimulus(1'b1, bad[k][1]);
      checks++;
      if ({write_req, frame_done, error, sync} !== 6'b000010) begin
        failures++;
        $display("[TB] FAIL bad_frame%0d: got %b expected 000010", k, {write_req, frame_done, error, sync});
      end
      apply_stimulus(1'b0, 8'h00);
      checks++;
      if (error !== 1'b0) begin
        failures++;
        $display("[TB] FAIL bad_frame%0d_pulse: got error=%b expected 0", k, error);
      end
    end
    apply_stimulus(1'b1, 8'hF2);
    apply_stimulus(1'b1, 8'h09);
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1'b1, 8'(8'h10 + i));
      checks++;
      if ({write_req, output_data, frame_done, error, sync} !== {3'b100, 8'(8'h10 + i), (i == 8), 1'b0, 1'b1}) begin
        failures++;
        $display("[TB] FAIL ch2_byte%0d: got wr=%b d=%h fd=%b err=%b sync=%b expected wr=100 d=%h fd=%0d err=0 sync=1", i, write_req, output_data, frame_done, error, sync, 8'(8'h10 + i), (i == 8));
      end
    end
    apply_stimulus(1'b1, 8'hF0);
    apply_stimulus(1'b1, 8'h01);
    apply_stimulus(1'b1, 8'hEE);
    checks++;
    if ({write_req, output_data, frame_done, error, sync} !== {3'b001, 8'hEE, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL len1_frame: got wr=%b d=%h fd=%b err=%b sync=%b expected wr=001 d=ee fd=1 err=0 sync=1", write_req, output_data, frame_done, error, sync);
    end
  endtask

  // Junk is silent while unlocked. A header nibble inside the payload is data.
  task automatic test_garbage_resync();
    logic [7:0] pay [9];
    pay = '{8'h55, 8'h66, 8'hF1, 8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    pulse_reset();
    apply_stimulus(1'b1, 8'h12);
    apply_stimulus(1'b1, 8'h34);
    checks++;
    if ({error, sync} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL unsynced_garbage: got err=%b sync=%b expected err=0 sync=0", error, sync);
    end
    apply_stimulus(1'b1, 8'hF0);
    apply_stimulus(1'b1, 8'h09);
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1'b1, pay[i]);
      checks++;
      if ({write_req, output_data, frame_done, error} !== {3'b001, pay[i], (i == 8), 1'b0}) begin
        failures++;
        $display("[TB] FAIL transparent_byte%0d: got wr=%b d=%h fd=%b err=%b expected wr=001 d=%h fd=%0d err=0", i, write_req, output_data, frame_done, error, pay[i], (i == 8));
      end
    end
    apply_stimulus(1'b1, 8'h12);
    checks++;
    if ({error, sync} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL synced_garbage: got err=%b sync=%b expected err=1 sync=0", error, sync);
    end
    apply_stimulus(1'b1, 8'h34);
    checks++;
    if ({error, sync} !== 2'b00) begin
      failures++;
      $display("[TB] FAIL garbage_after_loss: got err=%b sync=%b expected err=0 sync=0", error, sync);
    end
  endtask

  // Every byte is followed by an invalid cycle that carries a header-like byte
  task automatic test_valid_toggle();
    apply_stimulus(1'b1, 8'hF0);
    apply_stimulus(1'b0, 8'hF3);
    apply_stimulus(1'b1, 8'h09);
    apply_stimulus(1'b0, 8'hF3);
    checks++;
    if ({sync, error, channel} !== {1'b1, 1'b0, 4'h0}) begin
      failures++;
      $display("[TB] FAIL toggle_header: got sync=%b err=%b ch=%h expected sync=1 err=0 ch=0", sync, error, channel);
    end
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1'b1, 8'(8'h30 + i));
      checks++;
      if ({write_req, output_data, frame_done, error} !== {3'b001, 8'(8'h30 + i), (i == 8), 1'b0}) begin
        failures++;
        $display("[TB] FAIL toggle_byte%0d: got wr=%b d=%h fd=%b err=%b expected wr=001 d=%h fd=%0d err=0", i, write_req, output_data, frame_done, error, 8'(8'h30 + i), (i == 8));
      end
      apply_stimulus(1'b0, 8'hF3);
      checks++;
      if ({write_req, frame_done, error} !== 5'b00000) begin
        failures++;
        $display("[TB] FAIL toggle_gap%0d: got %b expected 00000", i, {write_req, frame_done, error});
      end
    end
  endtask

  // Reset in the middle of a payload, then a complete fresh frame
  task automatic test_reset_mid_frame();
    apply_stimulus(1'b1, 8'hF1);
    apply_stimulus(1'b1, 8'h09);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1'b1, 8'(8'hB0 + i));
      checks++;
      if ({write_req, output_data} !== {3'b010, 8'(8'hB0 + i)}) begin
        failures++;
        $display("[TB] FAIL partial_byte%0d: got wr=%b d=%h expected wr=010 d=%h", i, write_req, output_data, 8'(8'hB0 + i));
      end
    end
    @(negedge clk);
    input_valid = 1'b1;
    input_data  = 8'hB4;
    arst        = 1'b1;
    #1;
    checks++;
    if ({write_req, sync} !== 4'b0000) begin
      failures++;
      $display("[TB] FAIL async_reset: got wr=%b sync=%b expected wr=000 sync=0", write_req, sync);
    end
    @(posedge clk);
    #1;
    checks++;
    if (write_req !== 3'b000) begin
      failures++;
      $display("[TB] FAIL reset_held: got wr=%b expected 000", write_req);
    end
    @(negedge clk);
    arst = 1'b0;
    input_valid = 1'b0;
    apply_stimulus(1'b1, 8'hF1);
    apply_stimulus(1'b1, 8'h09);
    for (int i = 0; i < 9; i++) begin
      apply_stimulus(1'b1, 8'(8'hC0 + i));
      checks++;
      if ({write_req, output_data, frame_done, error, sync} !== {3'b010, 8'(8'hC0 + i), (i == 8), 1'b0, 1'b1}) begin
        failures++;
        $display("[TB] FAIL after_reset_byte%0d: got wr=%b d=%h fd=%b err=%b sync=%b expected wr=010 d=%h fd=%0d err=0 sync=1", i, write_req, output_data, frame_done, error, sync, 8'(8'hC0 + i), (i == 8));
      end
    end
  endtask

`ifdef DECOMM_ERR_CNT_EN
  // The count follows the registered error pulse by one clock
  task automatic test_err_count();
    pulse_reset();
    checks++;
    if (err_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL err_count_reset: got %0d expected 0", err_count);
    end
    apply_stimulus(1'b1, 8'hFF);
    apply_stimulus(1'b1, 8'h01);
    apply_stimulus(1'b1, 8'hF5);
    apply_stimulus(1'b1, 8'h00);
    apply_stimulus(1'b1, 8'hF0);
    apply_stimulus(1'b1, 8'h0A);
    apply_stimulus(1'b0, 8'h00);
    checks++;
    if (err_count !== 16'd3) begin
      failures++;
      $display("[TB] FAIL err_count_three: got %0d expected 3", err_count);
    end
    err_clr = 1'b1;
    apply_stimulus(1'b0, 8'h00);
    err_clr = 1'b0;
    checks++;
    if (err_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL err_count_clear: got %0d expected 0", err_count);
    end
    apply_stimulus(1'b1, 8'hFF);
    apply_stimulus(1'b1, 8'h01);
    err_clr = 1'b1;
    apply_stimulus(1'b0, 8'h00);
    err_clr = 1'b0;
    apply_stimulus(1'b0, 8'h00);
    checks++;
    if (err_count !== 16'd0) begin
      failures++;
      $display("[TB] FAIL err_count_clear_wins: got %0d expected 0", err_count);
    end
  endtask
`endif

  initial begin
    clk         = 1'b0;
    arst        = 1'b1;
    input_valid = 1'b0;
    input_data  = 8'h00;
`ifdef DECOMM_ERR_CNT_EN
    err_clr     = 1'b0;
`endif
    test_reset();
    test_ch1_frame();
    test_back_to_back();
    test_bad_frames();
    test_garbage_resync();
    test_valid_toggle();
    test_reset_mid_frame();
`ifdef DECOMM_ERR_CNT_EN
    test_err_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decommutator.md
Name: decommutator

Overview:
- Receive-side counterpart of the transmitter's channel commutator.
- Parses the framed byte stream, one byte per clock: header byte {4'hF, ch}, length byte, then `length` payload bytes.
- Routes each payload byte to its destination channel as a byte plus a one-hot write strobe.
- Sits between the link byte interface and the per-channel receive buffers.

Parameters:
- NUM_CH, 3, number of data channels; valid channel codes are 0..NUM_CH-1.
- MAX_LEN, 9, largest accepted payload length in bytes.
- IDLE_CH, 4'hF, channel code of the idle frame; its length byte must be 0.

Ports:
- clk  input  1  clock.
- arst  input  1  asynchronous active-high reset.
- input_valid  input  1  input_data holds a stream byte this cycle; tied high when driven by the transmitter.
- input_data  input  8  stream byte.
- write_req  output  NUM_CH  one-hot write strobe to the destination channel, one cycle wide.
- output_data  output  8  payload byte accompanying write_req.
- channel  output  4  channel code of the frame currently being received.
- frame_done  output  1  pulse with the last payload write of a frame, or with the length byte of an idle frame.
- sync  output  1  high while the receiver is locked to frame boundaries.
- error  output  1  one-cycle pulse on any framing violation.

Behaviour:
- Reset (arst high, async): state=HUNT, write_req=0, output_data=8'h00, channel=4'hF, frame_done=0, sync=0, error=0, byte counter=0.
- All outputs are registered. A byte sampled at edge N produces its write_req/output_data at edge N+1, so latency is 1 cycle.
- Cycles with input_valid=0 are ignored: no state change, and all strobes are 0 on the next cycle.
- FSM states: HUNT, LEN, DATA.
- HUNT:
  - Byte with upper nibble 4'hF: latch channel=low nibble, go to LEN.
  - Any other byte: pulse error only if sync=1, then clear sync and stay in HUNT.
- LEN:
  - If channel==IDLE_CH: len must be 0; otherwise pulse error, clear sync, go to HUNT.
  - If channel<NUM_CH: len must be in 1..MAX_LEN; otherwise pulse error, clear sync, go to HUNT.
  - If channel is neither IDLE_CH nor <NUM_CH: pulse error, clear sync, go to HUNT.
  - Len==0 on a valid idle frame: pulse frame_done, set sync, go to HUNT.
  - Otherwise: load counter=len, set sync, go to DATA.
- DATA:
  - Each valid byte: output_data<=byte, write_req<=1<<channel, counter decrements.
  - When counter==1: frame_done is pulsed together with that write, then go to HUNT.
- Back-to-back frames need no gap: a header byte may follow the last payload byte on the next cycle.
- Header nibble 4'hF inside DATA is payload, not a resync point; payload is transparent.
- Counter is 4 bits wide; MAX_LEN must be ≤15 (elaboration check).
- Reset mid-frame discards the partial frame. No write_req is issued after arst is asserted.

Optional Feature:
- Macro: DECOMM_ERR_CNT_EN.
- With the macro:
  - Adds output err_count (16 bits), reset to 0, incremented on every error pulse.
  - Saturates at 16'hFFFF.
  - Adds input err_clr (1 bit), synchronous clear. Clear wins over a simultaneous increment.
- Without the macro: neither port exists and no counter logic is generated.

Decomposition:
- Shared package (commutator_pkg):
  - state enum {HUNT, LEN, DATA}.
  - HDR_MARK=4'hF, IDLE_CH, NUM_CH, MAX_LEN.
  - Header field widths (marker 4, channel 4, length 8).
  - The transmitter uses the same constants.
- One natural sub-module: channel_decoder. It converts the 4-bit channel code to a NUM_CH one-hot vector plus a valid flag, and is the mirror of the transmitter's channel encoder.

Test Plan:
- Stream F1,09,A0..A8 after reset → 9 writes with write_req=3'b010 and output_data A0..A8 on consecutive cycles; frame_done with A8; sync=1.
- Idle frame FF,00 then F0,09,00..08 back-to-back → frame_done after 00; then 9 writes to channel 0, no gap cycle.
- F2,0A (len>MAX_LEN) → error pulse, sync=0, no writes; a following F2,09 frame is received correctly.
- Garbage 12,34 then F0,09 payload containing F1 → no error while unsynced; F1 is written as data to channel 0.
- input_valid toggled 1/0 every cycle during F0,09,... → each written byte is correct; timing stretches but data and order are unchanged.
- arst asserted after 4 payload bytes, released, then F1,09 frame → no writes after arst; the new frame completes normally. With DECOMM_ERR_CNT_EN: 3 errors → err_count=3; err_clr → 0.
